// File: rtl/regfile_rename_if.sv
// Decoder/ROB-facing bundle of the renamed register file: read ports, issue, commit and flush.
interface regfile_rename_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned ROBW = 4,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NCM  = 2
);
  localparam int unsigned RW = $clog2(NREG);

  logic                 rdy;
  logic [NRD*RW-1:0]    rd_reg;
  logic [NRD*XLEN-1:0]  rd_value;
  logic [NRD*ROBW-1:0]  rd_rob;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_valid;
  logic [RW-1:0]        iss_reg;
  logic [ROBW-1:0]      iss_rob;
  logic [NCM-1:0]       cm_valid;
  logic [NCM*RW-1:0]    cm_reg;
  logic [NCM*ROBW-1:0]  cm_rob;
  logic [NCM*XLEN-1:0]  cm_value;
  logic                 flush;

  modport master (
    output rdy, rd_reg, iss_valid, iss_reg, iss_rob,
           cm_valid, cm_reg, cm_rob, cm_value, flush,
    input  rd_value, rd_rob, rd_busy
  );

  modport slave (
    input  rdy, rd_reg, iss_valid, iss_reg, iss_rob,
           cm_valid, cm_reg, cm_rob, cm_value, flush,
    output rd_value, rd_rob, rd_busy
  );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with a rename table (RAT); combinational reads with
// same-cycle commit bypass, one rename per cycle, NCM commits per cycle, flush.
module regfile_rename #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned ROBW = 4,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NCM  = 2
) (
  input logic             clk,
  input logic             rst,
  regfile_rename_if.slave bus
);
  localparam int unsigned RW = $clog2(NREG);

  logic [XLEN-1:0] values_q [NREG];
  logic [XLEN-1:0] values_n [NREG];
  logic            busy_q   [NREG];
  logic            busy_n   [NREG];
  logic [ROBW-1:0] rename_q [NREG];
  logic [ROBW-1:0] rename_n [NREG];

  logic [NRD*XLEN-1:0] rd_value_c;
  logic [NRD*ROBW-1:0] rd_rob_c;
  logic [NRD-1:0]      rd_busy_c;
  logic [RW-1:0]       rd_idx;
  logic [XLEN-1:0]     rd_val;
  logic [ROBW-1:0]     rd_tag;
  logic                rd_bsy;
  logic [RW-1:0]       cm_idx;

  // Read ports: state before this cycle's issue, plus bypass from a matching commit.
  always_comb begin
    rd_value_c = '0;
    rd_rob_c   = '0;
    rd_busy_c  = '0;
    rd_idx     = '0;
    rd_val     = '0;
    rd_tag     = '0;
    rd_bsy     = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      rd_idx = bus.rd_reg[p*RW +: RW];
      rd_val = '0;
      rd_tag = '0;
      rd_bsy = 1'b0;
      if (rd_idx != '0) begin
        rd_val = values_q[rd_idx];
        rd_tag = rename_q[rd_idx];
        rd_bsy = busy_q[rd_idx];
        if (busy_q[rd_idx]) begin
          // Ascending scan so the youngest matching commit port wins.
          for (int k = 0; k < NCM; k++) begin
            if (bus.cm_valid[k] && bus.cm_reg[k*RW +: RW] == rd_idx &&
                bus.cm_rob[k*ROBW +: ROBW] == rename_q[rd_idx]) begin
              rd_bsy = 1'b0;
              rd_val = bus.cm_value[k*XLEN +: XLEN];
            end
          end
        end
      end
      rd_value_c[p*XLEN +: XLEN] = rd_val;
      rd_rob_c[p*ROBW +: ROBW]   = rd_tag;
      rd_busy_c[p]               = rd_bsy;
    end
  end

  assign bus.rd_value = rd_value_c;
  assign bus.rd_rob   = rd_rob_c;
  assign bus.rd_busy  = rd_busy_c;

  // Next state: commits, then issue, then flush; later steps override earlier ones.
  always_comb begin
    values_n = values_q;
    busy_n   = busy_q;
    rename_n = rename_q;
    cm_idx   = '0;
    if (bus.rdy) begin
      for (int k = 0; k < NCM; k++) begin
        cm_idx = bus.cm_reg[k*RW +: RW];
        if (bus.cm_valid[k] && cm_idx != '0) begin
          values_n[cm_idx] = bus.cm_value[k*XLEN +: XLEN];
          if (bus.cm_rob[k*ROBW +: ROBW] == rename_q[cm_idx]) busy_n[cm_idx] = 1'b0;
        end
      end
      if (bus.iss_valid && bus.iss_reg != '0) begin
        busy_n[bus.iss_reg]   = 1'b1;
        rename_n[bus.iss_reg] = bus.iss_rob;
      end
      if (bus.flush) begin
        for (int r = 0; r < NREG; r++) begin
          busy_n[r]   = 1'b0;
          rename_n[r] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      values_q <= '{default: '0};
      busy_q   <= '{default: 1'b0};
      rename_q <= '{default: '0};
    end else begin
      values_q <= values_n;
      busy_q   <= busy_n;
      rename_q <= rename_n;
    end
  end
endmodule
